// File: rtl/ascii_number_encoder.sv
// Converts a 32-bit unsigned value to decimal ASCII digits, most significant first.
// Uses a 32-cycle shift-and-add-3 conversion, then streams the digits over a valid/ready handshake.
module ascii_number_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_value,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] out_ascii,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_shift;
    logic [39:0] r_bcd;
    logic [4:0]  r_step;
    logic [3:0]  r_idx;

    logic [39:0] w_bcd_adj;
    logic [39:0] w_bcd_step;
    logic [31:0] w_shift_step;
    logic [3:0]  w_lead_idx;
    logic [3:0]  w_next_idx;

    function automatic logic [3:0] digit_at(input logic [39:0] bcd, input logic [3:0] idx);
        digit_at = 4'd0;
        for (int d = 0; d < 10; d++) begin
            if (idx == 4'(d)) digit_at = bcd[d*4 +: 4];
        end
    endfunction

    function automatic logic [11:0] to_ascii(input logic [3:0] digit);
        return 12'd48 + {8'd0, digit};
    endfunction

    // One double-dabble step: correct every digit >= 5, then shift the next input bit in.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < 10; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
        end
        w_bcd_step   = {w_bcd_adj[38:0], r_shift[31]};
        w_shift_step = {r_shift[30:0], 1'b0};
    end

    // Highest nonzero digit of the finished result; digit 0 when the value is zero.
    always_comb begin
        w_lead_idx = 4'd0;
        for (int d = 1; d < 10; d++) begin
            if (w_bcd_step[d*4 +: 4] != 4'd0) w_lead_idx = 4'(d);
        end
    end

    assign w_next_idx = r_idx - 4'd1;
    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);

    // NOTE: the BCD and shift registers are few enough to clear on reset, so an aborted
    // conversion leaves nothing behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= 32'd0;
            r_bcd     <= 40'd0;
            r_step    <= 5'd0;
            r_idx     <= 4'd0;
            out_valid <= 1'b0;
            out_ascii <= 12'd0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift <= in_value;
                        r_bcd   <= 40'd0;
                        r_step  <= 5'd0;
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_shift <= w_shift_step;
                    r_bcd   <= w_bcd_step;
                    r_step  <= r_step + 5'd1;
                    if (r_step == 5'd31) begin
                        r_state   <= EMIT;
                        r_idx     <= w_lead_idx;
                        out_valid <= 1'b1;
                        out_ascii <= to_ascii(digit_at(w_bcd_step, w_lead_idx));
                        out_last  <= (w_lead_idx == 4'd0);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (r_idx == 4'd0) begin
                            r_state   <= IDLE;
                            out_valid <= 1'b0;
                            out_ascii <= 12'd0;
                            out_last  <= 1'b0;
                        end else begin
                            r_idx     <= w_next_idx;
                            out_ascii <= to_ascii(digit_at(r_bcd, w_next_idx));
                            out_last  <= (w_next_idx == 4'd0);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_number_encoder.sv
// Self-checking bench for ascii_number_encoder: directed numbers against a decimal-string
// scoreboard, with latency, backpressure, abort-by-reset and busy-input cases.
module tb_ascii_number_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_ascii;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [11:0] exp_q[$];

    ascii_number_encoder dut (
        .clock     (clock),
        .reset     (reset),
        .in_value  (in_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ascii (out_ascii),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    // Reference: the decimal spelling of the value, no leading zeros.
    function automatic string dec_str(input logic [31:0] v);
        string       s;
        logic [31:0] t;
        s = "";
        t = v;
        do begin
            s = $sformatf("%0d%s", t % 10, s);
            t = t / 10;
        end while (t != 0);
        return s;
    endfunction

    // Compare process: every cycle, outputs either match the scoreboard head or are idle zeros.
    initial begin : monitor
        bit emitting;
        bit just_done;
        emitting  = 1'b0;
        just_done = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                emitting  = 1'b0;
                just_done = 1'b0;
                check("reset_out_valid", out_valid, 0);
            end else begin
                if (just_done) begin
                    check("after_last_valid", out_valid, 0);
                    check("after_last_in_ready", in_ready, 1);
                    just_done = 1'b0;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_digit", out_valid, 0);
                    end else begin
                        emitting = 1'b1;
                        check("digit", out_ascii, exp_q[0]);
                        check("last_flag", out_last, exp_q.size() == 1);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) begin
                                just_done = 1'b1;
                                emitting  = 1'b0;
                            end
                        end
                    end
                end else begin
                    check("idle_ascii_zero", out_ascii, 0);
                    check("idle_last_zero", out_last, 0);
                    if (emitting) check("bubble", out_valid, 1);
                end
            end
        end
    end

    // Drive one number through; optionally toggle out_ready, hold a second value on the input,
    // or abort with reset after a given number of consumed digits.
    task automatic run_number(input logic [31:0] v, input bit toggle, input bit hold,
                              input int abort_after);
        string s;
        int    guard;
        s         = dec_str(v);
        in_value  = v;
        in_valid  = 1'b1;
        out_ready = !toggle;
        guard = 0;
        while (!in_ready && guard < 10) begin
            @(posedge clock); #1;
            guard++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clock);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(12'(s[i]));
        #1;
        if (hold) in_value = 32'd77;
        else      in_valid = 1'b0;
        for (int k = 1; k < 32; k++) begin
            @(posedge clock); #1;
            if (toggle) out_ready = ~out_ready;
        end
        check("valid_before_32", out_valid, 0);
        check("busy_converting", busy, 1);
        @(posedge clock); #1;
        check("valid_at_32", out_valid, 1);
        if (toggle) out_ready = ~out_ready;

        if (abort_after > 0) begin
            repeat (abort_after) @(posedge clock);
            #1;
            reset = 1'b1;
            #1;
            check("abort_valid", out_valid, 0);
            check("abort_ascii", out_ascii, 0);
            check("abort_last", out_last, 0);
            check("abort_busy", busy, 0);
            check("abort_in_ready", in_ready, 1);
            exp_q.delete();
            in_valid = 1'b0;
            @(posedge clock); #1;
            reset = 1'b0;
            return;
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(posedge clock); #1;
            if (toggle) out_ready = ~out_ready;
            guard++;
        end
        check("drain_done", exp_q.size(), 0);
        if (hold) in_valid = 1'b0;
        check("in_ready_after", in_ready, 1);
        check("busy_after", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        check("stays_idle", busy, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        out_ready = 1'b0;

        check_str("model_0", dec_str(32'd0), "0");
        check_str("model_1000", dec_str(32'd1000), "1000");
        check_str("model_max", dec_str(32'hFFFFFFFF), "4294967295");
        check_str("model_507", dec_str(32'd507), "507");

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ascii", out_ascii, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;

        run_number(32'd0, 1'b0, 1'b0, 0);
        run_number(32'd1234, 1'b0, 1'b0, 0);
        run_number(32'd1000, 1'b0, 1'b0, 0);
        run_number(32'hFFFFFFFF, 1'b0, 1'b0, 0);
        run_number(32'd507, 1'b1, 1'b0, 0);
        run_number(32'd98765, 1'b0, 1'b0, 2);
        run_number(32'd3, 1'b0, 1'b0, 0);
        run_number(32'd42, 1'b0, 1'b1, 0);
        run_number(32'd100200, 1'b1, 1'b0, 0);

        repeat (3) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
